bcd_hex_counter: RTL and testbench

Six-digit decimal (BCD) counter that drives the DE-series HEX displays and LEDs, built to be instantiated inside `top` behind the `CLOCK_50`/`KEY`/`SW` pins. It has a programmable prescaler, run/direction switches, and a load from switches on a debounced-by-sync key press. It also registers seven-segment decode for all six digits. It is the counting stage whose outputs feed `HEX0`–`HEX5` and `LEDR`.

---
 rtl/bcd_hex_counter.sv | 157 +++++++++++++++
 tb/tb_bcd_hex_counter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_hex_counter.sv
// Six-digit BCD up/down counter with prescaler, synchronized key load and registered 7-seg/LED outputs.
// Define BCD_BLANK_LEADING_ZERO_EN to blank leading-zero digits on HEX1..HEX5.
module bcd_hex_counter #(
  parameter int TICK_DIV = 50000000
) (
  input  logic        CLOCK_50,
  input  logic        Resetn,
  input  logic        load_n,
  input  logic [9:0]  SW,
  output logic [23:0] count,
  output logic        wrap,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [9:0]  LEDR
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
`ifdef BCD_BLANK_LEADING_ZERO_EN
  localparam logic [6:0] HEX_HI_RST = 7'h7F;
`else
  localparam logic [6:0] HEX_HI_RST = 7'h40;
`endif

  function automatic logic [3:0] clamp9(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic          sync1_q, sync2_q, sync3_q, load_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [23:0]   count_q, count_d;
  logic          wrap_q, wrap_d;
  logic [6:0]    hex_q [6];
  logic [6:0]    hex_d [6];
  logic [9:0]    ledr_q;
  logic          led8_d;
  logic          run, up, tick;
  logic          carry;
  logic [3:0]    dig;
  logic [3:0]    dig_h;
`ifdef BCD_BLANK_LEADING_ZERO_EN
  logic          nz;
`endif

  assign run  = SW[9];
  assign up   = SW[8];
  assign tick = run && (presc_q == TICK_LAST);

  // A load restarts the step period so the first tick lands a full period later.
  always_comb begin
    presc_d = presc_q;
    if (load_q || tick) presc_d = '0;
    else if (run)       presc_d = presc_q + PW'(1);
  end

  // Ripple carry/borrow: a digit only changes while everything below it rolled over.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    carry   = 1'b1;
    dig     = 4'd0;
    if (load_q) begin
      count_d = {16'h0000, clamp9(SW[7:4]), clamp9(SW[3:0])};
    end else if (tick) begin
      for (int k = 0; k < 6; k++) begin
        dig = count_q[4*k +: 4];
        if (carry) begin
          if (up) begin
            if (dig == 4'd9) dig = 4'd0;
            else begin dig = dig + 4'd1; carry = 1'b0; end
          end else begin
            if (dig == 4'd0) dig = 4'd9;
            else begin dig = dig - 4'd1; carry = 1'b0; end
          end
        end
        count_d[4*k +: 4] = dig;
      end
      wrap_d = carry;
    end
  end

  always_comb begin
    dig_h = 4'd0;
`ifdef BCD_BLANK_LEADING_ZERO_EN
    nz = 1'b0;
    for (int k = 5; k >= 0; k--) begin
      dig_h    = count_q[4*k +: 4];
      nz       = nz | (dig_h != 4'd0);
      hex_d[k] = (k != 0 && !nz) ? 7'h7F : seg7(dig_h);
    end
`else
    for (int k = 0; k < 6; k++) begin
      dig_h    = count_q[4*k +: 4];
      hex_d[k] = seg7(dig_h);
    end
`endif
  end

  assign led8_d = wrap_q | (ledr_q[8] & ~load_q);

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      sync3_q  <= 1'b1;
      load_q   <= 1'b0;
      presc_q  <= '0;
      count_q  <= '0;
      wrap_q   <= 1'b0;
      ledr_q   <= '0;
      hex_q[0] <= 7'h40;
      for (int k = 1; k < 6; k++) hex_q[k] <= HEX_HI_RST;
    end else begin
      sync1_q <= load_n;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      load_q  <= sync3_q & ~sync2_q;
      presc_q <= presc_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ledr_q  <= {run, led8_d, count_q[7:0]};
      for (int k = 0; k < 6; k++) hex_q[k] <= hex_d[k];
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign HEX0  = hex_q[0];
  assign HEX1  = hex_q[1];
  assign HEX2  = hex_q[2];
  assign HEX3  = hex_q[3];
  assign HEX4  = hex_q[4];
  assign HEX5  = hex_q[5];
  assign LEDR  = ledr_q;

endmodule

// File: tb/tb_bcd_hex_counter.sv
// Self-checking bench for bcd_hex_counter: directed steps plus random run/dir/load traffic vs an arithmetic model.
`timescale 1ns/1ps
module tb_bcd_hex_counter;
  localparam int TD = 4;

  logic        CLOCK_50 = 1'b0;
  logic        Resetn;
  logic        load_n;
  logic [9:0]  SW;
  logic [23:0] count;
  logic        wrap;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [9:0]  LEDR;

  always #5 CLOCK_50 = ~CLOCK_50;

  bcd_hex_counter #(.TICK_DIV(TD)) dut (
    .CLOCK_50(CLOCK_50), .Resetn(Resetn), .load_n(load_n), .SW(SW),
    .count(count), .wrap(wrap),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
    .LEDR(LEDR)
  );

  int errors = 0;
  int checks = 0;

  // Model state: counter value as a plain integer, display value one edge behind.
  int         m_val, m_pre, m_hval;
  bit         m_runp, m_led8, m_wrap;
  bit         ln_h [4];
  logic [6:0] SEG [10];

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int x;
    r = '0;
    x = v;
    for (int k = 0; k < 6; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] exp_hex(input int v, input int k);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
`ifdef BCD_BLANK_LEADING_ZERO_EN
    if (k > 0 && v < p) return 7'h7F;
`endif
    return SEG[(v / p) % 10];
  endfunction

  task automatic model_reset();
    m_val = 0; m_pre = 0; m_hval = 0;
    m_runp = 1'b0; m_led8 = 1'b0; m_wrap = 1'b0;
    for (int i = 0; i < 4; i++) ln_h[i] = 1'b1;
  endtask

  task automatic model_edge();
    bit ld, run, up, tick;
    int hi, lo;
    if (!Resetn) begin
      model_reset();
      return;
    end
    // A key fall first sampled at edge N loads on edge N+3.
    ld   = ln_h[3] && !ln_h[2];
    run  = SW[9];
    up   = SW[8];
    tick = run && (m_pre == TD - 1);
    m_led8 = m_wrap ? 1'b1 : (ld ? 1'b0 : m_led8);
    m_hval = m_val;
    m_runp = run;
    m_wrap = 1'b0;
    if (ld) begin
      hi = int'(SW[7:4]); if (hi > 9) hi = 9;
      lo = int'(SW[3:0]); if (lo > 9) lo = 9;
      m_val = 10 * hi + lo;
    end else if (tick) begin
      if (up) begin
        m_wrap = (m_val == 999999);
        m_val  = (m_val + 1) % 1000000;
      end else begin
        m_wrap = (m_val == 0);
        m_val  = (m_val + 999999) % 1000000;
      end
    end
    m_pre = ld ? 0 : (run ? (m_pre + 1) % TD : m_pre);
    ln_h[3] = ln_h[2]; ln_h[2] = ln_h[1]; ln_h[1] = ln_h[0]; ln_h[0] = load_n;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic check_all(input string tag);
    logic [23:0] hb;
    hb = to_bcd(m_hval);
    chk({tag, " count"}, 32'(count), 32'(to_bcd(m_val)));
    chk({tag, " wrap"},  32'(wrap),  32'(m_wrap));
    chk({tag, " LEDR"},  32'(LEDR),  32'({m_runp, m_led8, hb[7:0]}));
    chk({tag, " HEX0"},  32'(HEX0),  32'(exp_hex(m_hval, 0)));
    chk({tag, " HEX1"},  32'(HEX1),  32'(exp_hex(m_hval, 1)));
    chk({tag, " HEX2"},  32'(HEX2),  32'(exp_hex(m_hval, 2)));
    chk({tag, " HEX3"},  32'(HEX3),  32'(exp_hex(m_hval, 3)));
    chk({tag, " HEX4"},  32'(HEX4),  32'(exp_hex(m_hval, 4)));
    chk({tag, " HEX5"},  32'(HEX5),  32'(exp_hex(m_hval, 5)));
  endtask

  task automatic step(input int n, input string tag);
    repeat (n) begin
      @(posedge CLOCK_50);
      model_edge();
      @(negedge CLOCK_50);
      check_all(tag);
    end
  endtask

  initial begin
    SEG[0] = 7'h40; SEG[1] = 7'h79; SEG[2] = 7'h24; SEG[3] = 7'h30; SEG[4] = 7'h19;
    SEG[5] = 7'h12; SEG[6] = 7'h02; SEG[7] = 7'h78; SEG[8] = 7'h00; SEG[9] = 7'h10;

    // Reset, then run up.
    SW = 10'b11_0000_0000; load_n = 1'b1; Resetn = 1'b0;
    model_reset();
    @(negedge CLOCK_50);
    check_all("in_reset");
    step(2, "in_reset");
    Resetn = 1'b1;
    step(4, "run_up");
    chk("count_at_4", 32'(count), 32'h000001);
    step(1, "run_up");
    chk("hex0_one", 32'(HEX0), 32'h79);
    step(3, "run_up");
    chk("count_at_8", 32'(count), 32'h000002);

    // Held key load with clamped nibble.
    SW = {1'b0, 1'b1, 8'h9F};
    load_n = 1'b0;
    step(4, "load9F");
    chk("load_99", 32'(count), 32'h000099);
    step(1, "load_held");
    load_n = 1'b1;
    step(4, "load_held");
    chk("no_repeat", 32'(count), 32'h000099);

    // Carry ripple 99 -> 100.
    SW[9] = 1'b1;
    step(4, "carry");
    chk("count_100", 32'(count), 32'h000100);
    step(1, "carry");
    chk("hex2_one", 32'(HEX2), 32'h79);

    // Down from zero wraps to 999999.
    SW = {1'b0, 1'b0, 8'h00};
    load_n = 1'b0;
    step(2, "load00");
    load_n = 1'b1;
    step(3, "load00");
    chk("count_0", 32'(count), 32'h000000);
    SW[9] = 1'b1;
    step(4, "down_wrap");
    chk("count_999999", 32'(count), 32'h999999);
    chk("wrap_high", 32'(wrap), 32'h1);
    step(1, "down_wrap");
    chk("wrap_pulse", 32'(wrap), 32'h0);
    chk("led8_set", 32'(LEDR[8]), 32'h1);
    SW = {1'b0, 1'b0, 8'h42};
    step(3, "led8_hold");
    load_n = 1'b0;
    step(1, "led8_clear");
    load_n = 1'b1;
    step(4, "led8_clear");
    chk("load_42", 32'(count), 32'h000042);
    chk("led8_cleared", 32'(LEDR[8]), 32'h0);

    // Load coinciding with a tick.
    SW = {1'b1, 1'b1, 8'h37};
    for (int i = 0; i < 8 && m_pre != 0; i++) step(1, "align");
    chk("aligned", 32'(m_pre), 32'h0);
    load_n = 1'b0;
    step(1, "collide");
    load_n = 1'b1;
    step(3, "collide");
    chk("collide_load", 32'(count), 32'h000037);
    step(3, "after_collide");
    chk("no_early_tick", 32'(count), 32'h000037);
    step(1, "after_collide");
    chk("tick_after_4", 32'(count), 32'h000038);

    // Random run/direction/load traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        SW[8:0] = 9'($urandom);
        SW[9]   = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 5) == 0) load_n = ~load_n;
      step(1, "rand");
    end
    load_n = 1'b1;
    step(4, "rand_tail");

    // Asynchronous reset between edges at 000123.
    SW = {1'b0, 1'b1, 8'h99};
    load_n = 1'b0;
    step(1, "pre123");
    load_n = 1'b1;
    step(4, "pre123");
    SW[9] = 1'b1;
    for (int i = 0; i < 200 && m_val != 123; i++) step(1, "to123");
    SW[9] = 1'b0;
    chk("count_123", 32'(count), 32'h000123);
    #2;
    Resetn = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    chk("async_count", 32'(count), 32'h000000);
    step(2, "async_hold");
    Resetn = 1'b1;
    SW[9] = 1'b1;
    step(4, "resume");
    chk("resume_1", 32'(count), 32'h000001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
